// File: rtl/pipeline_defs.sv
// Shared fetch-pipeline definitions: datapath width, bubble encoding and
// the fetch FSM state encoding.
package pipeline_defs;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2,
    S_STALL = 2'd3
  } fetch_state_e;

  // PC arithmetic is plain modulo-2^XLEN; alignment bits are left untouched.
  function automatic logic [XLEN-1:0] pc_advance(input logic [XLEN-1:0] pc,
                                                 input logic [XLEN-1:0] inc);
    return pc + inc;
  endfunction

endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry {instruction, pc} holding register that parks a fetch which
// completed while decode was frozen.
module fetch_skid_reg
  import pipeline_defs::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;

  // Clear wins so a redirect can never be overtaken by a stale entry.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC/redirect tracking, req/ack instruction-memory
// port, freeze skid buffering and the IF/ID register feeding decode.
module if_fetch_stage
  import pipeline_defs::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned     PC_INC    = 4,
  parameter logic [XLEN-1:0] NOP_INSTR = pipeline_defs::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            freeze,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_addr,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] pc_out,
  output logic            valid
);

  localparam logic [XLEN-1:0] INC = XLEN'(PC_INC);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] redir_q, redir_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pcout_q, pcout_d;
  logic            valid_q, valid_d;

  logic            skid_load, skid_clear, skid_vld;
  logic [XLEN-1:0] skid_instr, skid_pc;
  logic [XLEN-1:0] pc_next;

  assign pc_next = pc_advance(pc_q, INC);

  fetch_skid_reg u_skid (
    .clk_i   (clk),
    .rst_ni  (rst),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .instr_i (imem_rdata),
    .pc_i    (pc_next),
    .valid_o (skid_vld),
    .instr_o (skid_instr),
    .pc_o    (skid_pc)
  );

  // A request already on the bus cannot be retracted, so a redirect that
  // arrives before the ack is parked in redir_q until S_DRAIN sees the ack.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redir_d    = redir_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    case (state_q)
      S_BOOT: begin
        state_d = S_REQ;
        if (branch_taken) pc_d = branch_addr;
      end
      S_REQ: begin
        if (imem_ack) begin
          if (branch_taken) begin
            pc_d = branch_addr;
          end else begin
            pc_d = pc_next;
            if (freeze) begin
              skid_load = 1'b1;
              state_d   = S_STALL;
            end
          end
        end else if (branch_taken) begin
          redir_d = branch_addr;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (branch_taken) redir_d = branch_addr;
        if (imem_ack) begin
          pc_d    = branch_taken ? branch_addr : redir_q;
          state_d = S_REQ;
        end
      end
      S_STALL: begin
        if (branch_taken) begin
          skid_clear = 1'b1;
          pc_d       = branch_addr;
          state_d    = S_REQ;
        end else if (!freeze) begin
          skid_clear = 1'b1;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  // IF/ID register: redirect bubble beats freeze hold, skid beats live fetch.
  always_comb begin
    instr_d = instr_q;
    pcout_d = pcout_q;
    valid_d = valid_q;
    if (branch_taken) begin
      instr_d = NOP_INSTR;
      pcout_d = '0;
      valid_d = 1'b0;
    end else if (freeze) begin
      instr_d = instr_q;
    end else if (skid_vld) begin
      instr_d = skid_instr;
      pcout_d = skid_pc;
      valid_d = 1'b1;
    end else if ((state_q == S_REQ) && imem_ack) begin
      instr_d = imem_rdata;
      pcout_d = pc_next;
      valid_d = 1'b1;
    end else begin
      instr_d = NOP_INSTR;
      pcout_d = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      redir_q <= RESET_PC;
      instr_q <= NOP_INSTR;
      pcout_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
      instr_q <= instr_d;
      pcout_q <= pcout_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req    = (state_q == S_REQ) || (state_q == S_DRAIN);
  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign pc_out      = pcout_q;
  assign valid       = valid_q;

  a_addr_stable: assert property (@(posedge clk) disable iff (!rst)
    (imem_req && !imem_ack) |=> $stable(imem_addr));

  a_skid_only_in_stall: assert property (@(posedge clk) disable iff (!rst)
    skid_vld |-> (state_q == S_STALL));

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table, reset-in-drain sequence,
// then randomized traffic scored against a program-order reference model.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        valid;

  int passed = 0;
  int total  = 0;

  if_fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instruction  (instruction),
    .pc_out       (pc_out),
    .valid        (valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ack, frz, br;
    logic [31:0] baddr, rdata;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evld;
    logic [31:0] einstr, epc;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(logic ack, logic frz, logic br, logic [31:0] baddr,
                              logic [31:0] rdata, logic ereq, logic [31:0] eaddr,
                              logic evld, logic [31:0] einstr, logic [31:0] epc);
    vec_t v;
    v.ack = ack; v.frz = frz; v.br = br; v.baddr = baddr; v.rdata = rdata;
    v.ereq = ereq; v.eaddr = eaddr; v.evld = evld; v.einstr = einstr; v.epc = epc;
    return v;
  endfunction

  // Instruction memory contents as a pure function of the byte address.
  function automatic logic [31:0] memf(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_outputs(string tag, logic ereq, logic [31:0] eaddr, logic evld,
                             logic [31:0] einstr, logic [31:0] epc);
    chk({tag, ".req"},   {31'h0, imem_req}, {31'h0, ereq});
    chk({tag, ".addr"},  imem_addr, eaddr);
    chk({tag, ".valid"}, {31'h0, valid}, {31'h0, evld});
    chk({tag, ".instr"}, instruction, einstr);
    chk({tag, ".pc"},    pc_out, epc);
  endtask

  initial begin
    int          delivered;
    logic [31:0] exp_addr;
    logic        m_vld;
    logic [31:0] m_instr, m_pc;
    logic        pbr, fr, br, ack, req_prev;
    logic [31:0] baddr, addr_prev;

    // ack/freeze/branch/baddr/rdata driven this cycle; then req/addr/valid/instr/pc seen now
    tbl[0]  = mk(0,0,0,32'h0,        32'h0,        0,32'h0,        0,32'h0,        32'h0);
    tbl[1]  = mk(1,0,0,32'h0,        32'hE0810002, 1,32'h0,        0,32'h0,        32'h0);
    tbl[2]  = mk(1,0,0,32'h0,        32'hE2433001, 1,32'h4,        1,32'hE0810002, 32'h4);
    tbl[3]  = mk(0,0,0,32'h0,        32'hBAD00003, 1,32'h8,        1,32'hE2433001, 32'h8);
    tbl[4]  = mk(0,0,0,32'h0,        32'hBAD00004, 1,32'h8,        0,32'h0,        32'h0);
    tbl[5]  = mk(0,0,0,32'h0,        32'hBAD00005, 1,32'h8,        0,32'h0,        32'h0);
    tbl[6]  = mk(1,0,0,32'h0,        32'hE1A00000, 1,32'h8,        0,32'h0,        32'h0);
    tbl[7]  = mk(1,0,0,32'h0,        32'h11111111, 1,32'hC,        1,32'hE1A00000, 32'hC);
    tbl[8]  = mk(0,0,1,32'h100,      32'hBAD00008, 1,32'h10,       1,32'h11111111, 32'h10);
    tbl[9]  = mk(0,0,0,32'h0,        32'hBAD00009, 1,32'h10,       0,32'h0,        32'h0);
    tbl[10] = mk(1,0,0,32'h0,        32'hDEADBEEF, 1,32'h10,       0,32'h0,        32'h0);
    tbl[11] = mk(1,0,0,32'h0,        32'h22222222, 1,32'h100,      0,32'h0,        32'h0);
    tbl[12] = mk(1,0,1,32'h20,       32'h33333333, 1,32'h104,      1,32'h22222222, 32'h104);
    tbl[13] = mk(1,1,0,32'h0,        32'hE3A01005, 1,32'h20,       0,32'h0,        32'h0);
    tbl[14] = mk(0,1,0,32'h0,        32'hBAD0000E, 0,32'h24,       0,32'h0,        32'h0);
    tbl[15] = mk(0,0,0,32'h0,        32'hBAD0000F, 0,32'h24,       0,32'h0,        32'h0);
    tbl[16] = mk(1,1,0,32'h0,        32'h44444444, 1,32'h24,       1,32'hE3A01005, 32'h24);
    tbl[17] = mk(0,1,1,32'h200,      32'hBAD00011, 0,32'h28,       1,32'hE3A01005, 32'h24);
    tbl[18] = mk(0,0,0,32'h0,        32'hBAD00012, 1,32'h200,      0,32'h0,        32'h0);
    tbl[19] = mk(0,0,1,32'h300,      32'hBAD00013, 1,32'h200,      0,32'h0,        32'h0);
    tbl[20] = mk(0,0,0,32'h0,        32'hBAD00014, 1,32'h200,      0,32'h0,        32'h0);
    tbl[21] = mk(1,0,1,32'hFFFFFFFC, 32'h77777777, 1,32'h200,      0,32'h0,        32'h0);
    tbl[22] = mk(1,0,0,32'h0,        32'h66666666, 1,32'hFFFFFFFC, 0,32'h0,        32'h0);
    tbl[23] = mk(0,0,1,32'h400,      32'hBAD00017, 1,32'h0,        1,32'h66666666, 32'h0);
    tbl[24] = mk(0,0,0,32'h0,        32'hBAD00018, 1,32'h0,        0,32'h0,        32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk_outputs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 25; i++) begin
      chk_outputs($sformatf("vec%0d", i), tbl[i].ereq, tbl[i].eaddr, tbl[i].evld,
                  tbl[i].einstr, tbl[i].epc);
      imem_ack     = tbl[i].ack;
      freeze       = tbl[i].frz;
      branch_taken = tbl[i].br;
      branch_addr  = tbl[i].baddr;
      imem_rdata   = tbl[i].rdata;
      @(posedge clk);
      #1;
    end

    // Now in S_DRAIN with a redirect to 0x400 parked; reset mid-cycle abandons it.
    imem_ack = 1'b0; freeze = 1'b0; branch_taken = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk_outputs("rst_drain", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("boot.req", {31'h0, imem_req}, 32'h0);
    @(posedge clk);
    #1;
    chk_outputs("boot_req", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

    // Randomized phase: outputs must follow program order from the last redirect.
    delivered = 0;
    exp_addr  = 32'h0;
    m_vld = 1'b0; m_instr = 32'h0; m_pc = 32'h0;
    pbr = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      fr    = ($urandom_range(0, 3) == 0);
      br    = !pbr && ($urandom_range(0, 9) == 0);
      baddr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(0, 255)) << 2);
      ack   = imem_req && ($urandom_range(0, 1) == 1);
      req_prev  = imem_req;
      addr_prev = imem_addr;
      freeze       = fr;
      branch_taken = br;
      branch_addr  = baddr;
      imem_ack     = ack;
      imem_rdata   = ack ? memf(imem_addr) : $urandom;
      if (br) exp_addr = baddr;
      @(posedge clk);
      #1;
      if (br) begin
        chk("rnd.branch_bubble", {valid, instruction[30:0]} | pc_out, 32'h0);
        m_vld = 1'b0; m_instr = 32'h0; m_pc = 32'h0;
      end else if (fr) begin
        chk("rnd.hold", {31'h0, valid} ^ instruction ^ {pc_out[15:0], pc_out[31:16]},
            {31'h0, m_vld} ^ m_instr ^ {m_pc[15:0], m_pc[31:16]});
      end else if (valid) begin
        chk("rnd.pc_order", pc_out, exp_addr + 32'd4);
        chk("rnd.instr", instruction, memf(exp_addr));
        exp_addr = exp_addr + 32'd4;
        delivered++;
        m_vld = 1'b1; m_instr = instruction; m_pc = pc_out;
      end else begin
        chk("rnd.bubble", instruction | pc_out, 32'h0);
        m_vld = 1'b0; m_instr = 32'h0; m_pc = 32'h0;
      end
      if (req_prev && !ack) begin
        chk("rnd.req_held", {31'h0, imem_req}, 32'h1);
        chk("rnd.addr_stable", imem_addr, addr_prev);
      end
      pbr = br;
    end
    chk("rnd.progress", {31'h0, delivered >= 100}, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
